freq_meter: RTL and testbench

- Frequency meter that counts rising edges of an asynchronous, slow input signal over a fixed gate window timed from clk_in.
- It is the measuring counterpart to our clock divider: it checks divided or external clocks such as the 1 Hz tick and board test signals.
- The result is reported as edges per gate window, with a 1-cycle valid strobe and an overflow flag.

---
 rtl/freq_meter.sv | 112 +++++++++++
 tb/tb_freq_meter.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/freq_meter.sv
// Gated frequency meter: counts synchronized rising edges of sig_in over a
// GATE_CYCLES-long window and reports the count with a valid strobe.
module freq_meter #(
  parameter int GATE_CYCLES = 50000000,
  parameter int CNT_W       = 27
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             sig_in,
  input  logic             start,
  input  logic             continuous,
  output logic [CNT_W-1:0] freq_out,
  output logic             valid,
  output logic             overflow,
  output logic             busy
);

  localparam int GW = $clog2(GATE_CYCLES);
  localparam logic [GW-1:0] LAST = GW'(GATE_CYCLES - 1);

  typedef enum logic {IDLE, MEASURE} state_t;

  state_t           state_q, state_d;
  logic             s1_q, s2_q, s3_q;
  logic [GW-1:0]    gate_q, gate_d;
  logic [CNT_W-1:0] edge_q, edge_d;
  logic [CNT_W-1:0] freq_q, freq_d;
  logic             sat_q, sat_d;
  logic             ovf_q, ovf_d;
  logic             vld_q, vld_d;

  logic             rise;
  logic             at_max;
  logic [CNT_W-1:0] edge_nxt;
  logic             sat_nxt;

  assign rise   = s2_q & ~s3_q;
  assign at_max = &edge_q;

  // Saturating edge count including this cycle's rise; sat latches any
  // increment attempted while already at the maximum.
  assign edge_nxt = edge_q + {{(CNT_W-1){1'b0}}, rise & ~at_max};
  assign sat_nxt  = sat_q | (rise & at_max);

  always_comb begin
    state_d = state_q;
    gate_d  = gate_q;
    edge_d  = edge_q;
    sat_d   = sat_q;
    freq_d  = freq_q;
    ovf_d   = ovf_q;
    vld_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = MEASURE;
          gate_d  = '0;
          edge_d  = '0;
          sat_d   = 1'b0;
        end
      end
      MEASURE: begin
        if (gate_q == LAST) begin
          freq_d  = edge_nxt;
          ovf_d   = sat_nxt;
          vld_d   = 1'b1;
          gate_d  = '0;
          edge_d  = '0;
          sat_d   = 1'b0;
          state_d = continuous ? MEASURE : IDLE;
        end else begin
          gate_d = gate_q + GW'(1);
          edge_d = edge_nxt;
          sat_d  = sat_nxt;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!reset) begin
      state_q <= IDLE;
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      s3_q    <= 1'b0;
      gate_q  <= '0;
      edge_q  <= '0;
      sat_q   <= 1'b0;
      freq_q  <= '0;
      ovf_q   <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      s1_q    <= sig_in;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
      gate_q  <= gate_d;
      edge_q  <= edge_d;
      sat_q   <= sat_d;
      freq_q  <= freq_d;
      ovf_q   <= ovf_d;
      vld_q   <= vld_d;
    end
  end

  assign freq_out = freq_q;
  assign overflow = ovf_q;
  assign valid    = vld_q;
  assign busy     = (state_q == MEASURE);

endmodule

// File: tb/tb_freq_meter.sv
// Directed bench for freq_meter: two instances (8-bit and 4-bit counters)
// share stimulus, so saturation is exercised alongside the normal path.
module tb_freq_meter;

  logic       clk;
  logic       reset;
  logic       sig_in;
  logic       start;
  logic       continuous;
  logic [7:0] freq8;
  logic       valid8, ovf8, busy8;
  logic [3:0] freq4;
  logic       valid4, ovf4, busy4;

  int n_tests = 0;
  int n_fail  = 0;

  int sig_per = 4;
  bit sig_lvl = 1'b0;
  int ph      = 0;

  freq_meter #(.GATE_CYCLES(100), .CNT_W(8)) dut8 (
    .clk_in(clk), .reset(reset), .sig_in(sig_in), .start(start),
    .continuous(continuous), .freq_out(freq8), .valid(valid8),
    .overflow(ovf8), .busy(busy8)
  );

  freq_meter #(.GATE_CYCLES(100), .CNT_W(4)) dut4 (
    .clk_in(clk), .reset(reset), .sig_in(sig_in), .start(start),
    .continuous(continuous), .freq_out(freq4), .valid(valid4),
    .overflow(ovf4), .busy(busy4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Periodic sig_in with equal high/low phases, or static level when sig_per==0
  initial begin
    sig_in = 1'b0;
    forever begin
      @(negedge clk);
      if (sig_per == 0) sig_in = sig_lvl;
      else begin
        ph     = (ph + 1) % sig_per;
        sig_in = (ph < sig_per / 2);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic set_pattern(input int per, input bit lvl);
    sig_per = per;
    sig_lvl = lvl;
    ph      = 0;
    repeat (12) @(negedge clk);
  endtask

  // One start pulse, wait for valid; returns latency and busy-high samples.
  task automatic do_window(input logic [7:0] hold_exp, output int lat, output int bcnt);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat  = 0;
    bcnt = busy8 ? 1 : 0;
    while (!valid8 && lat < 300) begin
      @(negedge clk);
      lat++;
      if (lat == 50) chk("hold_freq", freq8, hold_exp);
      if (!valid8 && busy8) bcnt++;
    end
  endtask

  typedef struct {
    string name;
    int    per;
    bit    lvl;
    int    f8;
    bit    o8;
    int    f4;
    bit    o4;
  } vec_t;

  vec_t vec[6];

  initial begin
    int lat, bcnt, cnt, vcnt;
    logic [7:0] prev8;

    vec[0] = '{"p10",     10, 1'b0, 10, 1'b0, 10, 1'b0};
    vec[1] = '{"p4",       4, 1'b0, 25, 1'b0, 15, 1'b1};
    vec[2] = '{"p10_b",   10, 1'b0, 10, 1'b0, 10, 1'b0};
    vec[3] = '{"static1",  0, 1'b1,  0, 1'b0,  0, 1'b0};
    vec[4] = '{"p20",     20, 1'b0,  5, 1'b0,  5, 1'b0};
    vec[5] = '{"static0",  0, 1'b0,  0, 1'b0,  0, 1'b0};

    reset = 1'b0; start = 1'b0; continuous = 1'b0;

    // Reset held with sig_in toggling
    repeat (3) begin
      @(negedge clk);
      chk("rst_freq8", freq8, 0);
      chk("rst_valid8", valid8, 0);
      chk("rst_ovf8", ovf8, 0);
      chk("rst_busy8", busy8, 0);
      chk("rst_busy4", busy4, 0);
    end
    reset = 1'b1;
    @(negedge clk);

    prev8 = 8'd0;
    for (int i = 0; i < 6; i++) begin
      set_pattern(vec[i].per, vec[i].lvl);
      do_window(prev8, lat, bcnt);
      chk({vec[i].name, "_lat"}, lat, 100);
      chk({vec[i].name, "_busy"}, bcnt, 100);
      chk({vec[i].name, "_freq8"}, freq8, vec[i].f8);
      chk({vec[i].name, "_ovf8"}, ovf8, vec[i].o8);
      chk({vec[i].name, "_freq4"}, freq4, vec[i].f4);
      chk({vec[i].name, "_ovf4"}, ovf4, vec[i].o4);
      chk({vec[i].name, "_busy_end"}, busy8, 0);
      @(negedge clk);
      chk({vec[i].name, "_vld_pulse"}, valid8, 0);
      prev8 = vec[i].f8[7:0];
    end

    // Continuous mode: back-to-back windows, ignored starts, late drop
    set_pattern(20, 1'b0);
    continuous = 1'b1;
    do_window(prev8, lat, bcnt);
    chk("cont_lat0", lat, 100);
    chk("cont_freq0", freq8, 5);
    chk("cont_busy0", busy8, 1);
    for (int w = 0; w < 3; w++) begin
      cnt = 0;
      do begin
        @(negedge clk);
        cnt++;
        if (cnt == 30) start = 1'b1;
        if (cnt == 31) start = 1'b0;
        if (w == 2 && cnt == 50) continuous = 1'b0;
      end while (!valid8 && cnt < 300);
      chk("cont_interval", cnt, 100);
      chk("cont_freq", freq8, 5);
      chk("cont_busy", busy8, (w == 2) ? 0 : 1);
    end
    vcnt = 0;
    repeat (120) begin
      @(negedge clk);
      if (valid8 || busy8) vcnt++;
    end
    chk("cont_stopped", vcnt, 0);

    // Reset in the middle of a window aborts it
    set_pattern(10, 1'b0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (50) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    chk("mid_rst_busy", busy8, 0);
    chk("mid_rst_freq", freq8, 0);
    chk("mid_rst_ovf4", ovf4, 0);
    chk("mid_rst_valid", valid8, 0);
    vcnt = 0;
    repeat (120) begin
      @(negedge clk);
      if (valid8 || busy8) vcnt++;
    end
    chk("mid_rst_quiet", vcnt, 0);
    do_window(8'd0, lat, bcnt);
    chk("after_rst_lat", lat, 100);
    chk("after_rst_freq8", freq8, 10);
    chk("after_rst_ovf8", ovf8, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
